// File: rtl/framebuffer_scanout.sv
// framebuffer_scanout: raster timing generator that streams a linear framebuffer
// RAM out as pixels with hsync/vsync/frame_start, 2-clock read-to-pixel pipeline.
// Ports: clock, reset_n (async, active low); rd_addr -> RAM, rd_data <- RAM
//   (1-clock latency); pixel_data, pixel_valid, hsync, vsync, frame_start out.
// Option: SCANOUT_TEST_PATTERN_EN adds input pattern_sel (x^y test pattern).
module framebuffer_scanout #(
  parameter int   DATA_WIDTH = 8,
  parameter int   ADDR_WIDTH = 19,
  parameter int   H_ACTIVE   = 640,
  parameter int   H_FRONT    = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BACK     = 48,
  parameter int   V_ACTIVE   = 480,
  parameter int   V_FRONT    = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BACK     = 33,
  parameter logic SYNC_POL   = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset_n,
`ifdef SCANOUT_TEST_PATTERN_EN
  input  logic                  pattern_sel,
`endif
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] pixel_data,
  output logic                  pixel_valid,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  // +1 so the sync-end bound still fits when the back porch is zero
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [HW-1:0] H_ONE  = HW'(1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [VW-1:0] V_ONE  = VW'(1);

  localparam logic [ADDR_WIDTH-1:0] A_LAST =
    ADDR_WIDTH'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);

  logic [HW-1:0]         r_h;
  logic [VW-1:0]         r_v;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;

  logic w_h_wrap;
  logic w_v_wrap;
  logic w_frame_wrap;
  logic w_active;
  logic w_hs_on;
  logic w_vs_on;
  logic w_fs;

  logic r_s1_act;
  logic r_s1_hs;
  logic r_s1_vs;
  logic r_s1_fs;

  logic [DATA_WIDTH-1:0] w_pix_src;
  logic [DATA_WIDTH-1:0] r_pix;
  logic                  r_valid;
  logic                  r_hsync;
  logic                  r_vsync;
  logic                  r_fs;

  assign w_h_wrap     = (r_h == H_LAST);
  assign w_v_wrap     = (r_v == V_LAST);
  assign w_frame_wrap = w_h_wrap && w_v_wrap;
  assign w_active     = (r_h < H_ACT) && (r_v < V_ACT);
  assign w_hs_on      = (r_h >= H_SS) && (r_h < H_SE);
  assign w_vs_on      = (r_v >= V_SS) && (r_v < V_SE);
  assign w_fs         = (r_h == '0) && (r_v == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_h_wrap) begin
      r_h <= '0;
      r_v <= w_v_wrap ? '0 : r_v + V_ONE;
    end else begin
      r_h <= r_h + H_ONE;
    end
  end

  // Address tracks the pixel being read; it holds through blanking and
  // saturates on the last pixel so vertical blanking never runs past RAM.
  always_comb begin
    w_addr_nxt = r_addr;
    unique case (1'b1)
      w_frame_wrap: w_addr_nxt = '0;
      (w_active && (r_addr != A_LAST)): w_addr_nxt = r_addr + A_ONE;
      default: w_addr_nxt = r_addr;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_addr <= '0;
    end else begin
      r_addr <= w_addr_nxt;
    end
  end

  assign rd_addr = r_addr;

  // Stage 1: conditions wait here while the RAM read is in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_act <= 1'b0;
      r_s1_hs  <= 1'b0;
      r_s1_vs  <= 1'b0;
      r_s1_fs  <= 1'b0;
    end else begin
      r_s1_act <= w_active;
      r_s1_hs  <= w_hs_on;
      r_s1_vs  <= w_vs_on;
      r_s1_fs  <= w_fs;
    end
  end

`ifdef SCANOUT_TEST_PATTERN_EN
  logic [7:0] r_s1_x;
  logic [7:0] r_s1_y;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_x <= '0;
      r_s1_y <= '0;
    end else begin
      r_s1_x <= 8'(r_h);
      r_s1_y <= 8'(r_v);
    end
  end

  always_comb begin
    w_pix_src = rd_data;
    if (pattern_sel) begin
      w_pix_src = DATA_WIDTH'(r_s1_x ^ r_s1_y);
    end
  end
`else
  assign w_pix_src = rd_data;
`endif

  // Stage 2: output registers, pixel blanked outside active video.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pix   <= '0;
      r_valid <= 1'b0;
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
      r_fs    <= 1'b0;
    end else begin
      r_pix   <= r_s1_act ? w_pix_src : '0;
      r_valid <= r_s1_act;
      r_hsync <= r_s1_hs ? SYNC_POL : ~SYNC_POL;
      r_vsync <= r_s1_vs ? SYNC_POL : ~SYNC_POL;
      r_fs    <= r_s1_fs;
    end
  end

  assign pixel_data  = r_pix;
  assign pixel_valid = r_valid;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// tb_framebuffer_scanout: randomized scoreboard bench for framebuffer_scanout
// using a tiny 8x6 raster and a 1-clock RAM with mem[a] = a + 8'h10.
module tb_framebuffer_scanout;

  localparam int HA = 4;
  localparam int HF = 1;
  localparam int HS = 2;
  localparam int HB = 1;
  localparam int VA = 3;
  localparam int VF = 1;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam logic SP = 1'b0;
`ifdef SCANOUT_TEST_PATTERN_EN
  localparam bit HAS_PAT = 1'b1;
`else
  localparam bit HAS_PAT = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] pd;
    logic       pv;
    logic       hs;
    logic       vs;
    logic       fs;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] pixel_data;
  logic       pixel_valid;
  logic       hsync;
  logic       vsync;
  logic       frame_start;
`ifdef SCANOUT_TEST_PATTERN_EN
  logic       pattern_sel = 1'b0;
`endif

  exp_t       pq[$];
  logic [3:0] aq[$];
  int         checks = 0;
  int         failures = 0;
  int         t = 0;
  bit         pat = 1'b0;
  exp_t       rst_e;

  framebuffer_scanout #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4),
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(SP)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
`ifdef SCANOUT_TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .pixel_data(pixel_data),
    .pixel_valid(pixel_valid),
    .hsync(hsync),
    .vsync(vsync),
    .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  always @(posedge clock) rd_data <= 8'(rd_addr) + 8'h10;

  // Address = count of active pixels already scanned in this frame, capped.
  function automatic logic [3:0] model_addr(int tt);
    int h = tt % HT;
    int v = (tt / HT) % VT;
    int n;
    if (v < VA) n = v * HA + ((h < HA) ? h : HA);
    else n = HA * VA;
    if (n > HA * VA - 1) n = HA * VA - 1;
    return 4'(n);
  endfunction

  function automatic exp_t model_out(int tt);
    int h = tt % HT;
    int v = (tt / HT) % VT;
    exp_t e;
    bit act = (h < HA) && (v < VA);
    e.pv = act;
    e.hs = (h >= HA + HF && h < HA + HF + HS) ? SP : ~SP;
    e.vs = (v >= VA + VF && v < VA + VF + VS) ? SP : ~SP;
    e.fs = (h == 0) && (v == 0);
    if (!act) e.pd = 8'h00;
    else if (HAS_PAT && pat) e.pd = 8'(h ^ v);
    else e.pd = 8'(v * HA + h + 16);
    return e;
  endfunction

  task automatic push_state();
    pq.push_back(model_out(t));
    aq.push_back(model_addr(t));
  endtask

  task automatic chk_rst(string tag);
    exp_t g;
    g = {pixel_data, pixel_valid, hsync, vsync, frame_start};
    checks++;
    if (g !== rst_e || rd_addr !== 4'd0) begin
      failures++;
      $display("FAIL %s got pd=%h pv=%b hs=%b vs=%b fs=%b addr=%0d want pd=00 pv=0 hs=1 vs=1 fs=0 addr=0",
               tag, g.pd, g.pv, g.hs, g.vs, g.fs, rd_addr);
    end
  endtask

  // Called at posedge+1: that cycle is the first post-reset raster state.
  task automatic release_rst(bit p);
`ifdef SCANOUT_TEST_PATTERN_EN
    pattern_sel = p;
`endif
    pat = p;
    reset_n = 1'b1;
    t = 0;
    pq.push_back(rst_e);
    pq.push_back(rst_e);
    push_state();
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    t++;
    push_state();
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic assert_rst(int n, bit p);
    #2;
    reset_n = 1'b0;
    pq.delete();
    aq.delete();
    repeat (n) @(posedge clock);
    #1;
    release_rst(p);
  endtask

  always @(negedge reset_n) begin
    #1;
    chk_rst("rst_async");
  end

  always @(negedge clock) begin
    exp_t e;
    exp_t g;
    logic [3:0] a;
    if (!reset_n) begin
      chk_rst("rst_hold");
    end else if (pq.size() == 0 || aq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_underflow got empty queue want entry at t=%0d", t);
    end else begin
      e = pq.pop_front();
      a = aq.pop_front();
      g = {pixel_data, pixel_valid, hsync, vsync, frame_start};
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL pix t=%0d got pd=%h pv=%b hs=%b vs=%b fs=%b want pd=%h pv=%b hs=%b vs=%b fs=%b",
                 t, g.pd, g.pv, g.hs, g.vs, g.fs, e.pd, e.pv, e.hs, e.vs, e.fs);
      end
      checks++;
      if (rd_addr !== a) begin
        failures++;
        $display("FAIL rd_addr t=%0d got %0d want %0d", t, rd_addr, a);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_e = '{pd: 8'h00, pv: 1'b0, hs: ~SP, vs: ~SP, fs: 1'b0};
    #2;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    release_rst(1'b0);
    run(3 * HT * VT);

    // Reset in the middle of a frame while reading address 7.
    while (model_addr(t) != 4'd7) step();
    checks++;
    if (rd_addr !== 4'd7) begin
      failures++;
      $display("FAIL mid_addr got %0d want 7", rd_addr);
    end
    assert_rst(2, 1'b0);
    run(60);

    if (HAS_PAT) begin
      assert_rst(1, 1'b1);
      run(HT * VT + 10);
    end

    for (int i = 0; i < 10; i++) begin
      run($urandom_range(5, 120));
      assert_rst($urandom_range(1, 4), HAS_PAT && ($urandom_range(0, 1) == 1));
    end
    run(2 * HT * VT);
    @(negedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
